// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_gray_rx.sv
//------------------------------------------------------------------------------
// Module  : nv_nvdla_csb_master_falcon2csb_fifo_gray_rx
// Brief   : Read-side pointer tracker of the falcon2csb async FIFO; optional
//           gray-transition checker enabled by NV_FALCON2CSB_GRAY_CHK_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nv_nvdla_csb_master_falcon2csb_fifo_gray_rx #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [PTR_W-1:0] wr_gray,
    input  logic             rd_pop,
    output logic [PTR_W-1:0] rd_gray,
    output logic [PTR_W-2:0] rd_adr,
    output logic             rd_empty,
    output logic [PTR_W-1:0] rd_count,
    output logic             gray_err
);

    logic [PTR_W-1:0] sync1_q, sync1_d;
    logic [PTR_W-1:0] sync2_q, sync2_d;
    logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
    logic             pop_ok;

    always_comb begin
        sync1_d  = wr_gray;
        sync2_d  = sync1_q;
        // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
        wr_bin_d = '0;
        for (int i = 0; i < PTR_W; i++) begin
            wr_bin_d[i] = ^(sync2_q >> i);
        end
        pop_ok    = rd_pop & ~rd_empty;
        rd_bin_d  = rd_bin_q + {{(PTR_W-1){1'b0}}, pop_ok};
        rd_gray_d = (rd_bin_d >> 1) ^ rd_bin_d;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
        end
    end

    assign rd_gray  = rd_gray_q;
    assign rd_adr   = rd_bin_q[PTR_W-2:0];
    assign rd_empty = (wr_bin_q == rd_bin_q);
    assign rd_count = wr_bin_q - rd_bin_q;

`ifdef NV_FALCON2CSB_GRAY_CHK_EN
    logic [PTR_W-1:0] prev_sync_q, prev_sync_d;
    logic [PTR_W-1:0] sync_diff;
    logic             multi_bit;
    logic             chk_en_q, chk_en_d;
    logic             gray_err_q, gray_err_d;

    always_comb begin
        prev_sync_d = sync2_q;
        sync_diff   = sync2_q ^ prev_sync_q;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi_bit   = |(sync_diff & (sync_diff - {{(PTR_W-1){1'b0}}, 1'b1}));
        chk_en_d    = 1'b1;
        gray_err_d  = gray_err_q | (chk_en_q & multi_bit);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            prev_sync_q <= '0;
            chk_en_q    <= 1'b0;
            gray_err_q  <= 1'b0;
        end else begin
            prev_sync_q <= prev_sync_d;
            chk_en_q    <= chk_en_d;
            gray_err_q  <= gray_err_d;
        end
    end

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nv_nvdla_csb_master_falcon2csb_fifo_gray_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_nv_nvdla_csb_master_falcon2csb_fifo_gray_rx
// Brief   : Self-checking bench: vector table plus hand sequences, scoreboarded.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nv_nvdla_csb_master_falcon2csb_fifo_gray_rx;

`ifdef NV_FALCON2CSB_GRAY_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic       empty;
        logic [2:0] count;
        logic [2:0] gray;
        logic [1:0] adr;
        logic       err;
    } exp_t;

    typedef struct {
        logic [2:0] wg;
        logic       pop;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       reset_;
    logic [2:0] wr_gray;
    logic       rd_pop;
    logic [2:0] rd_gray;
    logic [1:0] rd_adr;
    logic       rd_empty;
    logic [2:0] rd_count;
    logic       gray_err;

    int   n_checks;
    int   n_err;
    exp_t exp_q[$];
    vec_t tbl[19];

    nv_nvdla_csb_master_falcon2csb_fifo_gray_rx #(.PTR_W(3)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .wr_gray  (wr_gray),
        .rd_pop   (rd_pop),
        .rd_gray  (rd_gray),
        .rd_adr   (rd_adr),
        .rd_empty (rd_empty),
        .rd_count (rd_count),
        .gray_err (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic exp_t mk(input logic em, input logic [2:0] c, input logic [2:0] g,
                                input logic [1:0] a, input logic er);
        exp_t e;
        e.empty = em; e.count = c; e.gray = g; e.adr = a; e.err = er;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Compare the current DUT outputs against the oldest queued expectation.
    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".empty"}, 32'(rd_empty), 32'(e.empty));
            chk({tag, ".count"}, 32'(rd_count), 32'(e.count));
            chk({tag, ".gray"},  32'(rd_gray),  32'(e.gray));
            chk({tag, ".adr"},   32'(rd_adr),   32'(e.adr));
            chk({tag, ".err"},   32'(gray_err), 32'(e.err));
        end
    endtask

    task automatic step(input logic [2:0] wg, input logic pop, input exp_t e, input string tag);
        wr_gray = wg;
        rd_pop  = pop;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset();
        reset_  = 1'b0;
        wr_gray = 3'b000;
        rd_pop  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        logic [2:0] wb;
        n_checks = 0;
        n_err    = 0;

        // Latency, fill/drain, ignored pop, simultaneous pop + write.
        tbl[0]  = '{3'b001, 1'b0, mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0)};
        tbl[1]  = '{3'b001, 1'b0, mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0)};
        tbl[2]  = '{3'b011, 1'b0, mk(1'b0, 3'd1, 3'b000, 2'd0, 1'b0)};
        tbl[3]  = '{3'b010, 1'b0, mk(1'b0, 3'd1, 3'b000, 2'd0, 1'b0)};
        tbl[4]  = '{3'b110, 1'b0, mk(1'b0, 3'd2, 3'b000, 2'd0, 1'b0)};
        tbl[5]  = '{3'b110, 1'b0, mk(1'b0, 3'd3, 3'b000, 2'd0, 1'b0)};
        tbl[6]  = '{3'b110, 1'b0, mk(1'b0, 3'd4, 3'b000, 2'd0, 1'b0)};
        tbl[7]  = '{3'b110, 1'b1, mk(1'b0, 3'd3, 3'b001, 2'd1, 1'b0)};
        tbl[8]  = '{3'b110, 1'b1, mk(1'b0, 3'd2, 3'b011, 2'd2, 1'b0)};
        tbl[9]  = '{3'b110, 1'b1, mk(1'b0, 3'd1, 3'b010, 2'd3, 1'b0)};
        tbl[10] = '{3'b110, 1'b1, mk(1'b1, 3'd0, 3'b110, 2'd0, 1'b0)};
        tbl[11] = '{3'b110, 1'b1, mk(1'b1, 3'd0, 3'b110, 2'd0, 1'b0)};
        tbl[12] = '{3'b111, 1'b0, mk(1'b1, 3'd0, 3'b110, 2'd0, 1'b0)};
        tbl[13] = '{3'b101, 1'b0, mk(1'b1, 3'd0, 3'b110, 2'd0, 1'b0)};
        tbl[14] = '{3'b100, 1'b0, mk(1'b0, 3'd1, 3'b110, 2'd0, 1'b0)};
        tbl[15] = '{3'b100, 1'b0, mk(1'b0, 3'd2, 3'b110, 2'd0, 1'b0)};
        tbl[16] = '{3'b100, 1'b1, mk(1'b0, 3'd2, 3'b111, 2'd1, 1'b0)};
        tbl[17] = '{3'b100, 1'b1, mk(1'b0, 3'd1, 3'b101, 2'd2, 1'b0)};
        tbl[18] = '{3'b100, 1'b1, mk(1'b1, 3'd0, 3'b100, 2'd3, 1'b0)};

        reset_  = 1'b0;
        wr_gray = 3'b000;
        rd_pop  = 1'b0;
        #3;
        exp_q.push_back(mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0));
        check_out("reset_low");
        do_reset();
        exp_q.push_back(mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0));
        check_out("reset_release");

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].wg, tbl[i].pop, tbl[i].e, $sformatf("vec[%0d]", i));
        end

        // Wrap: eight write/pop pairs from reset; rd_empty must stay high until visible.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            wb = 3'(k);
            step(bin2gray(wb), 1'b0, mk(1'b1, 3'd0, bin2gray(3'(k - 1)), 2'(k - 1), 1'b0),
                 $sformatf("wrap%0d.s1", k));
            step(bin2gray(wb), 1'b0, mk(1'b1, 3'd0, bin2gray(3'(k - 1)), 2'(k - 1), 1'b0),
                 $sformatf("wrap%0d.s2", k));
            step(bin2gray(wb), 1'b0, mk(1'b0, 3'd1, bin2gray(3'(k - 1)), 2'(k - 1), 1'b0),
                 $sformatf("wrap%0d.vis", k));
            step(bin2gray(wb), 1'b1, mk(1'b1, 3'd0, bin2gray(wb), 2'(k), 1'b0),
                 $sformatf("wrap%0d.pop", k));
        end

        // Illegal two-bit jump, then asynchronous reset mid-stream.
        do_reset();
        step(3'b011, 1'b0, mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0),    "err.s1");
        step(3'b011, 1'b0, mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0),    "err.s2");
        step(3'b011, 1'b0, mk(1'b0, 3'd2, 3'b000, 2'd0, EXP_ERR), "err.set");
        step(3'b011, 1'b1, mk(1'b0, 3'd1, 3'b001, 2'd1, EXP_ERR), "err.pop");
        step(3'b011, 1'b0, mk(1'b0, 3'd1, 3'b001, 2'd1, EXP_ERR), "err.sticky");
        #2;
        reset_  = 1'b0;
        wr_gray = 3'b000;
        rd_pop  = 1'b0;
        #1;
        exp_q.push_back(mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0));
        check_out("midreset");
        @(negedge clk);
        reset_ = 1'b1;
        step(3'b000, 1'b0, mk(1'b1, 3'd0, 3'b000, 2'd0, 1'b0), "postreset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nv_nvdla_csb_master_falcon2csb_fifo_gray_rx.md
# nv_nvdla_csb_master_falcon2csb_fifo_gray_rx

Read-side pointer tracker for the falcon2csb asynchronous FIFO, in the CSB master clock domain. It receives the write-side gray pointer, which is asynchronous to clk, and synchronizes it. It then decodes the pointer to binary and maintains the local read pointer in binary and gray. It produces the read address, empty flag and occupancy count, and returns the read gray pointer to the write domain for its full computation.

## Interface
- PTR_W, default 3: pointer width including the wrap bit. FIFO depth is 2^(PTR_W-1); the default gives 4 entries.
- clk  input  1  read-domain clock
- reset_  input  1  reset, asynchronous, active-low
- wr_gray  input  PTR_W  write pointer in reflected gray code; asynchronous to clk; changes at most one bit per write-domain update
- rd_pop  input  1  pop request for the head entry; honoured only when rd_empty=0
- rd_gray  output  PTR_W  registered read pointer in gray code, sent to the write domain
- rd_adr  output  PTR_W-1  RAM read address, equal to rd_bin[PTR_W-2:0]
- rd_empty  output  1  FIFO empty as seen by the read side
- rd_count  output  PTR_W  occupancy, range 0..2^(PTR_W-1)
- gray_err  output  1  sticky illegal-gray-transition flag; see Configuration

## Operation
- Synchronizer: wr_gray passes through two flops, sync1 then sync2, with no logic between them. All are reset to 0.
- Decode: binary bit b[PTR_W-1] = g[PTR_W-1]; b[i] = b[i+1] ^ g[i]. The decoded value is registered into wr_bin_q, reset 0.
- Read pointer: rd_bin is a PTR_W-bit register, reset 0.
  - pop_ok = rd_pop & ~rd_empty.
  - On pop_ok, rd_bin <= rd_bin+1 modulo 2^PTR_W.
  - rd_gray is registered as (rd_bin_next >> 1) ^ rd_bin_next, so it always equals the gray code of rd_bin.
  - rd_gray changes exactly one bit per pop.
- rd_count = (wr_bin_q - rd_bin) mod 2^PTR_W. It is combinational from registers.
- rd_empty = (wr_bin_q == rd_bin).
- rd_adr = low PTR_W-1 bits of rd_bin.
- Pop while empty is ignored: no pointer change and no error.
- Wrap: rd_bin and rd_gray roll over after 2^PTR_W pops. With PTR_W=3, the rd_gray sequence is 000,001,011,010,110,111,101,100,000.
- A pop and a newly synchronized write pointer in the same cycle are both applied. Next-cycle rd_count = old count + write delta − 1.
- Reset mid-operation asynchronously clears every register, including gray_err. All outputs go to their reset values immediately.

## Timing
- Reset values:
  - rd_gray=0, rd_adr=0, rd_count=0
  - rd_empty=1, gray_err=0
- Write-pointer latency: a wr_gray change that is stable before edge N is visible in rd_empty/rd_count after edge N+2 (sync1 at N, sync2 at N+1, wr_bin_q at N+2). That is 3 clk edges of latency, plus up to 1 edge of metastability uncertainty.
- Pop latency: rd_pop sampled at edge N updates rd_bin, rd_gray, rd_adr, rd_empty and rd_count after edge N.
- Back-to-back pops on consecutive cycles are supported at 1 pop/cycle while rd_empty=0.
- rd_empty is pessimistic, never optimistic: it can stay high for up to 3 cycles after a write, but never deasserts before data is written.

## Configuration
- Macro NV_FALCON2CSB_GRAY_CHK_EN.
- Defined:
  - A register prev_sync holds the previous sync2 value.
  - If popcount(sync2 ^ prev_sync) > 1, gray_err sets on the next edge.
  - gray_err is sticky until reset_.
  - The check is disabled for the first cycle after reset.
- Undefined: no check logic; gray_err is tied to 0.
- Pointer behaviour is identical in both builds.

## Test plan
- Reset: hold reset_=0, then release -> rd_gray=000, rd_adr=00, rd_empty=1, rd_count=0, gray_err=0.
- Latency: wr_gray 000->001 stable before edge 0 -> rd_empty=0 and rd_count=1 after edge 2, not before.
- Fill/drain: wr_gray stepped to 110 (binary 4) -> rd_count=4; four pops -> rd_gray 001,011,010,110, rd_adr 1,2,3,0, rd_empty=1 after the 4th pop; a 5th pop is ignored.
- Simultaneous: with rd_count=2, pop on the same edge that wr_bin_q advances by 1 -> rd_count=2 next cycle.
- Wrap: 8 write/pop pairs -> rd_gray returns to 000 and rd_count=0 with no glitch on rd_empty.
- Error and reset: wr_gray jumps 000->011 -> gray_err=1 (macro defined) and stays 1; asserting reset_ mid-stream clears all outputs. With the macro undefined, gray_err stays 0.
